// File: rtl/mem_issue_queue_pkg.sv
// Shared constants for the memory issue queue: opcodes, fixed field widths and
// the issue-packet width helper.
package mem_issue_queue_pkg;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  localparam int unsigned UopW  = 7;
  localparam int unsigned PcW   = 32;
  localparam int unsigned FuncW = 10;
  localparam int unsigned ImmW  = 32;

  // Packet layout, MSB first: {val, uop, brmask, rd, pc, func, imm, prs2, prs1}
  function automatic int unsigned instr_width(input int unsigned brm_w,
                                              input int unsigned reg_w,
                                              input int unsigned prg_w);
    return 1 + UopW + brm_w + reg_w + PcW + FuncW + ImmW + 2 * prg_w;
  endfunction

endpackage

// File: rtl/mem_iq_entry.sv
// One issue-queue slot: operand wakeup, branch-kill check and memory-ordering
// eligibility. Storage lives in the top so compaction can move it freely.
module mem_iq_entry
  import mem_issue_queue_pkg::*;
#(
  parameter int unsigned WIDTH_BRM = 4,
  parameter int unsigned WIDTH_PRG = 6
) (
  input  logic                    valid_i,
  input  logic                    is_st_i,
  input  logic                    is_head_i,
  input  logic                    older_st_i,
  input  logic [WIDTH_BRM-1:0]    brmask_i,
  input  logic [WIDTH_PRG-1:0]    prs1_i,
  input  logic                    rdy1_i,
  input  logic [WIDTH_PRG-1:0]    prs2_i,
  input  logic                    rdy2_i,
  input  logic [WIDTH_PRG:0]      wk0_i,
  input  logic [WIDTH_PRG:0]      wk1_i,
  input  logic [2**WIDTH_BRM-1:0] brkill_i,
  output logic                    rdy1_o,
  output logic                    rdy2_o,
  output logic                    killed_o,
  output logic                    ready_o
);

  logic hit1, hit2;

  assign hit1 = (wk0_i[WIDTH_PRG] && (wk0_i[WIDTH_PRG-1:0] == prs1_i)) ||
                (wk1_i[WIDTH_PRG] && (wk1_i[WIDTH_PRG-1:0] == prs1_i));
  assign hit2 = (wk0_i[WIDTH_PRG] && (wk0_i[WIDTH_PRG-1:0] == prs2_i)) ||
                (wk1_i[WIDTH_PRG] && (wk1_i[WIDTH_PRG-1:0] == prs2_i));

  assign rdy1_o   = rdy1_i | hit1;
  assign rdy2_o   = rdy2_i | hit2;
  assign killed_o = valid_i & brkill_i[brmask_i];

  // Stores go only from the head; loads wait for every older store to leave.
  assign ready_o = valid_i & ~killed_o & rdy1_i &
                   (is_st_i ? (is_head_i & rdy2_i) : ~older_st_i);

endmodule

// File: rtl/mem_issue_queue.sv
// Collapsing issue queue for loads/stores: oldest-first select, age-preserving
// compaction and a registered issue packet for register-read.
module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WIDTH_BRM = 4,
  parameter int unsigned WIDTH_PRG = 6,
  parameter int unsigned WIDTH_REG = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_we,
  input  logic [UopW-1:0]         i_uop,
  input  logic [WIDTH_BRM-1:0]    i_brmask,
  input  logic [WIDTH_REG-1:0]    i_rd,
  input  logic [PcW-1:0]          i_pc,
  input  logic [FuncW-1:0]        i_func,
  input  logic [ImmW-1:0]         i_imm,
  input  logic [WIDTH_PRG-1:0]    i_prs1,
  input  logic [WIDTH_PRG-1:0]    i_prs2,
  input  logic                    i_rdy1,
  input  logic                    i_rdy2,
  input  logic [WIDTH_PRG:0]      i_wk0,
  input  logic [WIDTH_PRG:0]      i_wk1,
  input  logic [2**WIDTH_BRM-1:0] i_brkill,
  output logic                    o_full,
  output logic [instr_width(WIDTH_BRM, WIDTH_REG, WIDTH_PRG)-1:0] o_instr
);

  localparam int unsigned IdxW   = $clog2(DEPTH);
  localparam int unsigned CntW   = IdxW + 1;
  localparam int unsigned InstrW = instr_width(WIDTH_BRM, WIDTH_REG, WIDTH_PRG);

  logic [DEPTH-1:0]                valid_q, valid_d, is_st_q, is_st_d;
  logic [DEPTH-1:0]                rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [DEPTH-1:0][UopW-1:0]      uop_q, uop_d;
  logic [DEPTH-1:0][WIDTH_BRM-1:0] brmask_q, brmask_d;
  logic [DEPTH-1:0][WIDTH_REG-1:0] rd_q, rd_d;
  logic [DEPTH-1:0][PcW-1:0]       pc_q, pc_d;
  logic [DEPTH-1:0][FuncW-1:0]     func_q, func_d;
  logic [DEPTH-1:0][ImmW-1:0]      imm_q, imm_d;
  logic [DEPTH-1:0][WIDTH_PRG-1:0] prs1_q, prs1_d, prs2_q, prs2_d;
  logic [CntW-1:0]                 count_q, count_d;

  logic [DEPTH-1:0] rdy1_nxt, rdy2_nxt, killed, ready, older_st, issue, surv;
  logic             seen_st, sel_val, accept, in_rdy1, in_rdy2;
  logic [IdxW-1:0]  sel_idx;
  logic [CntW-1:0]  wr_idx;

  assign o_full = (count_q == CntW'(DEPTH));

  always_comb begin
    older_st = '0;
    seen_st  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      older_st[i] = seen_st;
      seen_st     = seen_st | (valid_q[i] & is_st_q[i]);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    mem_iq_entry #(
      .WIDTH_BRM (WIDTH_BRM),
      .WIDTH_PRG (WIDTH_PRG)
    ) u_entry (
      .valid_i    (valid_q[g]),
      .is_st_i    (is_st_q[g]),
      .is_head_i  (g == 0),
      .older_st_i (older_st[g]),
      .brmask_i   (brmask_q[g]),
      .prs1_i     (prs1_q[g]),
      .rdy1_i     (rdy1_q[g]),
      .prs2_i     (prs2_q[g]),
      .rdy2_i     (rdy2_q[g]),
      .wk0_i      (i_wk0),
      .wk1_i      (i_wk1),
      .brkill_i   (i_brkill),
      .rdy1_o     (rdy1_nxt[g]),
      .rdy2_o     (rdy2_nxt[g]),
      .killed_o   (killed[g]),
      .ready_o    (ready[g])
    );
  end

  // Lowest set bit of ready is the oldest eligible entry.
  assign issue   = ready & (~ready + DEPTH'(1));
  assign sel_val = |ready;
  assign surv    = valid_q & ~killed & ~issue;

  always_comb begin
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) sel_idx = IdxW'(i);
    end
  end

  assign in_rdy1 = i_rdy1 |
                   (i_wk0[WIDTH_PRG] && (i_wk0[WIDTH_PRG-1:0] == i_prs1)) |
                   (i_wk1[WIDTH_PRG] && (i_wk1[WIDTH_PRG-1:0] == i_prs1));
  assign in_rdy2 = i_rdy2 |
                   (i_wk0[WIDTH_PRG] && (i_wk0[WIDTH_PRG-1:0] == i_prs2)) |
                   (i_wk1[WIDTH_PRG] && (i_wk1[WIDTH_PRG-1:0] == i_prs2));
  assign accept  = i_we & ~o_full & ~i_brkill[i_brmask];

  always_comb begin
    valid_d  = '0;
    is_st_d  = is_st_q;
    rdy1_d   = rdy1_q;
    rdy2_d   = rdy2_q;
    uop_d    = uop_q;
    brmask_d = brmask_q;
    rd_d     = rd_q;
    pc_d     = pc_q;
    func_d   = func_q;
    imm_d    = imm_q;
    prs1_d   = prs1_q;
    prs2_d   = prs2_q;
    wr_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (surv[i]) begin
        valid_d[wr_idx[IdxW-1:0]]  = 1'b1;
        is_st_d[wr_idx[IdxW-1:0]]  = is_st_q[i];
        rdy1_d[wr_idx[IdxW-1:0]]   = rdy1_nxt[i];
        rdy2_d[wr_idx[IdxW-1:0]]   = rdy2_nxt[i];
        uop_d[wr_idx[IdxW-1:0]]    = uop_q[i];
        brmask_d[wr_idx[IdxW-1:0]] = brmask_q[i];
        rd_d[wr_idx[IdxW-1:0]]     = rd_q[i];
        pc_d[wr_idx[IdxW-1:0]]     = pc_q[i];
        func_d[wr_idx[IdxW-1:0]]   = func_q[i];
        imm_d[wr_idx[IdxW-1:0]]    = imm_q[i];
        prs1_d[wr_idx[IdxW-1:0]]   = prs1_q[i];
        prs2_d[wr_idx[IdxW-1:0]]   = prs2_q[i];
        wr_idx                     = wr_idx + CntW'(1);
      end
    end
    // accept implies count < DEPTH, so wr_idx is a legal slot here.
    if (accept) begin
      valid_d[wr_idx[IdxW-1:0]]  = 1'b1;
      is_st_d[wr_idx[IdxW-1:0]]  = (i_uop == STORE);
      rdy1_d[wr_idx[IdxW-1:0]]   = in_rdy1;
      rdy2_d[wr_idx[IdxW-1:0]]   = in_rdy2;
      uop_d[wr_idx[IdxW-1:0]]    = i_uop;
      brmask_d[wr_idx[IdxW-1:0]] = i_brmask;
      rd_d[wr_idx[IdxW-1:0]]     = i_rd;
      pc_d[wr_idx[IdxW-1:0]]     = i_pc;
      func_d[wr_idx[IdxW-1:0]]   = i_func;
      imm_d[wr_idx[IdxW-1:0]]    = i_imm;
      prs1_d[wr_idx[IdxW-1:0]]   = i_prs1;
      prs2_d[wr_idx[IdxW-1:0]]   = i_prs2;
    end
    count_d = wr_idx + CntW'(accept);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    is_st_q  <= is_st_d;
    rdy1_q   <= rdy1_d;
    rdy2_q   <= rdy2_d;
    uop_q    <= uop_d;
    brmask_q <= brmask_d;
    rd_q     <= rd_d;
    pc_q     <= pc_d;
    func_q   <= func_d;
    imm_q    <= imm_d;
    prs1_q   <= prs1_d;
    prs2_q   <= prs2_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_instr <= '0;
    end else if (sel_val) begin
      o_instr <= {1'b1, uop_q[sel_idx], brmask_q[sel_idx], rd_q[sel_idx], pc_q[sel_idx],
                  func_q[sel_idx], imm_q[sel_idx], prs2_q[sel_idx], prs1_q[sel_idx]};
    end else begin
      o_instr[InstrW-1] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench for mem_issue_queue: issue order, wakeup timing, memory
// ordering, branch kill, full handling and reset.
module tb_mem_issue_queue;
  import mem_issue_queue_pkg::*;

  localparam int unsigned PW = instr_width(4, 5, 6);

  logic          i_clk = 1'b0;
  logic          i_rst_n, i_we, i_rdy1, i_rdy2;
  logic [6:0]    i_uop;
  logic [3:0]    i_brmask;
  logic [4:0]    i_rd;
  logic [31:0]   i_pc, i_imm;
  logic [9:0]    i_func;
  logic [5:0]    i_prs1, i_prs2;
  logic [6:0]    i_wk0, i_wk1;
  logic [15:0]   i_brkill;
  logic          o_full;
  logic [PW-1:0] o_instr;

  int total = 0;
  int bad   = 0;

  mem_issue_queue #(
    .DEPTH     (8),
    .WIDTH_BRM (4),
    .WIDTH_PRG (6),
    .WIDTH_REG (5)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_we     (i_we),
    .i_uop    (i_uop),
    .i_brmask (i_brmask),
    .i_rd     (i_rd),
    .i_pc     (i_pc),
    .i_func   (i_func),
    .i_imm    (i_imm),
    .i_prs1   (i_prs1),
    .i_prs2   (i_prs2),
    .i_rdy1   (i_rdy1),
    .i_rdy2   (i_rdy2),
    .i_wk0    (i_wk0),
    .i_wk1    (i_wk1),
    .i_brkill (i_brkill),
    .o_full   (o_full),
    .o_instr  (o_instr)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [PW-1:0] pkt(input logic [6:0] uop, input logic [3:0] brm,
                                        input logic [4:0] rd, input logic [31:0] pc,
                                        input logic [5:0] p1, input logic [5:0] p2);
    return {1'b1, uop, brm, rd, pc, pc[11:2], pc + 32'h1000, p2, p1};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic disp(input logic [6:0] uop, input logic [3:0] brm, input logic [4:0] rd,
                      input logic [31:0] pc, input logic [5:0] p1, input logic r1,
                      input logic [5:0] p2, input logic r2);
    i_we     = 1'b1;
    i_uop    = uop;
    i_brmask = brm;
    i_rd     = rd;
    i_pc     = pc;
    i_func   = pc[11:2];
    i_imm    = pc + 32'h1000;
    i_prs1   = p1;
    i_rdy1   = r1;
    i_prs2   = p2;
    i_rdy2   = r2;
  endtask

  task automatic chk_val(input string tag, input logic exp);
    total++;
    assert (o_instr[PW-1] === exp) else begin
      bad++;
      $error("FAIL %s: val=%0b expected %0b", tag, o_instr[PW-1], exp);
    end
  endtask

  task automatic chk_pkt(input string tag, input logic [PW-1:0] exp);
    total++;
    assert (o_instr === exp) else begin
      bad++;
      $error("FAIL %s: instr=%h expected %h", tag, o_instr, exp);
    end
  endtask

  task automatic chk_full(input string tag, input logic exp);
    total++;
    assert (o_full === exp) else begin
      bad++;
      $error("FAIL %s: full=%0b expected %0b", tag, o_full, exp);
    end
  endtask

  initial begin
    i_rst_n  = 1'b0;
    i_we     = 1'b0;
    i_uop    = '0;
    i_brmask = '0;
    i_rd     = '0;
    i_pc     = '0;
    i_func   = '0;
    i_imm    = '0;
    i_prs1   = '0;
    i_prs2   = '0;
    i_rdy1   = 1'b0;
    i_rdy2   = 1'b0;
    i_wk0    = '0;
    i_wk1    = '0;
    i_brkill = '0;
    tick();
    tick();
    chk_pkt("rst_instr", '0);
    chk_full("rst_full", 1'b0);
    i_rst_n = 1'b1;

    // Ready load into an empty queue: visible one edge after it is written.
    disp(LOAD, 4'd0, 5'd1, 32'h100, 6'd1, 1'b1, 6'd2, 1'b0);
    tick();
    chk_val("ld_rdy_pre", 1'b0);
    i_we = 1'b0;
    tick();
    chk_pkt("ld_rdy_issue", pkt(LOAD, 4'd0, 5'd1, 32'h100, 6'd1, 6'd2));
    tick();
    chk_val("ld_rdy_empty", 1'b0);

    // Wakeup on a waiting entry.
    disp(LOAD, 4'd0, 5'd2, 32'h200, 6'd5, 1'b0, 6'd3, 1'b0);
    tick();
    i_we = 1'b0;
    chk_val("wk_wait0", 1'b0);
    tick();
    chk_val("wk_wait1", 1'b0);
    i_wk0 = {1'b1, 6'd5};
    tick();
    chk_val("wk_edge", 1'b0);
    i_wk0 = '0;
    tick();
    chk_pkt("wk_issue", pkt(LOAD, 4'd0, 5'd2, 32'h200, 6'd5, 6'd3));
    tick();
    chk_val("wk_empty", 1'b0);

    // Wakeup in the same cycle as dispatch.
    disp(LOAD, 4'd1, 5'd3, 32'h240, 6'd7, 1'b0, 6'd0, 1'b0);
    i_wk1 = {1'b1, 6'd7};
    tick();
    chk_val("wk_disp_pre", 1'b0);
    i_we  = 1'b0;
    i_wk1 = '0;
    tick();
    chk_pkt("wk_disp_issue", pkt(LOAD, 4'd1, 5'd3, 32'h240, 6'd7, 6'd0));
    tick();
    chk_val("wk_disp_empty", 1'b0);

    // Unready store at head blocks a ready younger load.
    disp(STORE, 4'd0, 5'd4, 32'h300, 6'd2, 1'b1, 6'd9, 1'b0);
    tick();
    chk_val("st_pre", 1'b0);
    disp(LOAD, 4'd0, 5'd5, 32'h304, 6'd3, 1'b1, 6'd0, 1'b0);
    tick();
    chk_val("st_block0", 1'b0);
    i_we = 1'b0;
    tick();
    chk_val("st_block1", 1'b0);
    i_wk1 = {1'b1, 6'd9};
    tick();
    chk_val("st_wake_edge", 1'b0);
    i_wk1 = '0;
    tick();
    chk_pkt("st_issue", pkt(STORE, 4'd0, 5'd4, 32'h300, 6'd2, 6'd9));
    tick();
    chk_pkt("st_then_ld", pkt(LOAD, 4'd0, 5'd5, 32'h304, 6'd3, 6'd0));
    tick();
    chk_val("st_empty", 1'b0);

    // Branch kill of tag 2 entries; survivors keep age order.
    disp(LOAD, 4'd2, 5'd6, 32'h400, 6'd10, 1'b0, 6'd0, 1'b0);
    tick();
    disp(LOAD, 4'd3, 5'd6, 32'h404, 6'd11, 1'b0, 6'd0, 1'b0);
    tick();
    disp(LOAD, 4'd2, 5'd6, 32'h408, 6'd12, 1'b0, 6'd0, 1'b0);
    tick();
    disp(LOAD, 4'd3, 5'd6, 32'h40c, 6'd13, 1'b0, 6'd0, 1'b0);
    tick();
    disp(LOAD, 4'd2, 5'd7, 32'h410, 6'd14, 1'b1, 6'd0, 1'b0);
    i_brkill = 16'h0004;
    tick();
    chk_val("kill_edge", 1'b0);
    i_we     = 1'b0;
    i_brkill = '0;
    i_wk0    = {1'b1, 6'd11};
    i_wk1    = {1'b1, 6'd13};
    tick();
    chk_val("kill_in_dropped", 1'b0);
    i_wk0 = '0;
    i_wk1 = '0;
    tick();
    chk_pkt("kill_surv0", pkt(LOAD, 4'd3, 5'd6, 32'h404, 6'd11, 6'd0));
    tick();
    chk_pkt("kill_surv1", pkt(LOAD, 4'd3, 5'd6, 32'h40c, 6'd13, 6'd0));
    tick();
    chk_val("kill_drained", 1'b0);
    i_wk0 = {1'b1, 6'd10};
    i_wk1 = {1'b1, 6'd12};
    tick();
    chk_val("kill_gone0", 1'b0);
    i_wk0 = '0;
    i_wk1 = '0;
    tick();
    chk_val("kill_gone1", 1'b0);

    // A ready entry killed in its selection cycle never issues.
    disp(LOAD, 4'd6, 5'd8, 32'h480, 6'd15, 1'b1, 6'd0, 1'b0);
    tick();
    chk_val("kill_sel_pre", 1'b0);
    i_we     = 1'b0;
    i_brkill = 16'h0040;
    tick();
    chk_val("kill_sel", 1'b0);
    i_brkill = '0;
    tick();
    chk_val("kill_sel_after", 1'b0);

    // Fill to DEPTH with unready loads.
    for (int i = 0; i < 8; i++) begin
      disp(LOAD, 4'd0, 5'(i), 32'h500 + 32'(4 * i), 6'(20 + i), 1'b0, 6'd0, 1'b0);
      tick();
      chk_full("fill", (i == 7));
    end
    disp(LOAD, 4'd0, 5'd9, 32'h600, 6'd30, 1'b1, 6'd0, 1'b0);
    tick();
    chk_full("full_9th", 1'b1);
    chk_val("full_9th_val", 1'b0);
    i_we  = 1'b0;
    i_wk0 = {1'b1, 6'd23};
    tick();
    chk_val("full_wake_edge", 1'b0);
    chk_full("full_hold", 1'b1);
    i_wk0 = '0;
    disp(LOAD, 4'd0, 5'd10, 32'h700, 6'd31, 1'b1, 6'd0, 1'b0);
    tick();
    chk_pkt("full_issue", pkt(LOAD, 4'd0, 5'd3, 32'h50c, 6'd23, 6'd0));
    chk_full("full_drop", 1'b0);
    i_we = 1'b0;
    tick();
    chk_val("full_disp_blocked", 1'b0);
    tick();
    chk_val("full_9th_dropped", 1'b0);

    // Reset with 7 waiting entries, then wake every tag they held.
    i_rst_n = 1'b0;
    i_wk0   = {1'b1, 6'd20};
    i_wk1   = {1'b1, 6'd21};
    tick();
    chk_pkt("mid_rst_instr", '0);
    chk_full("mid_rst_full", 1'b0);
    i_rst_n = 1'b1;
    i_wk0   = {1'b1, 6'd22};
    i_wk1   = {1'b1, 6'd24};
    tick();
    chk_val("post_rst0", 1'b0);
    i_wk0 = {1'b1, 6'd25};
    i_wk1 = {1'b1, 6'd26};
    tick();
    chk_val("post_rst1", 1'b0);
    i_wk0 = {1'b1, 6'd27};
    i_wk1 = '0;
    tick();
    chk_val("post_rst2", 1'b0);
    i_wk0 = '0;
    tick();
    chk_val("post_rst3", 1'b0);
    tick();
    chk_val("post_rst4", 1'b0);
    chk_full("post_rst_full", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
